// File: rtl/atm_account_arbiter_pkg.sv
// rtl/atm_account_arbiter_pkg.sv - shared opcodes, status codes and FSM encoding
package atm_arb_pkg;

    localparam logic [1:0] OP_INQ = 2'b00;
    localparam logic [1:0] OP_WDR = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NSF = 2'b01;
    localparam logic [1:0] ST_ILL = 2'b10;
    localparam logic [1:0] ST_OVF = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GRANT  = 2'b01,
        S_EXEC   = 2'b10,
        S_COMMIT = 2'b11
    } arb_state_t;

endpackage

// File: rtl/atm_account_arbiter_if.sv
// rtl/atm_account_arbiter_if.sv - session-controller to account-arbiter bundle
interface atm_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      op;
    logic [DATA_W*NUM_REQ-1:0] amount;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      done;
    logic [ID_W-1:0]           done_id;
    logic [1:0]                status;
    logic [DATA_W-1:0]         old_balance;
    logic [DATA_W-1:0]         new_balance;
    logic [DATA_W-1:0]         balance;

    modport master (
        output req, op, amount,
        input  grant, busy, done, done_id, status, old_balance, new_balance, balance
    );

    modport slave (
        input  req, op, amount,
        output grant, busy, done, done_id, status, old_balance, new_balance, balance
    );
endinterface

// File: rtl/atm_account_arbiter_rr_arbiter.sv
// rtl/atm_account_arbiter_rr_arbiter.sv - combinational round-robin pick starting at i_rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant_onehot,
    output logic [ID_W-1:0]    o_grant_idx
);
    logic [ID_W-1:0] w_cand [NUM_REQ];
    logic            w_found;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand[i] = ID_W'((int'(i_rr_ptr) + i) % NUM_REQ);
        end
    end

    // Candidates are visited in priority order, so the first hit wins.
    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        w_found        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[w_cand[i]]) begin
                w_found                     = 1'b1;
                o_grant_idx                 = w_cand[i];
                o_grant_onehot[w_cand[i]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/atm_account_arbiter.sv
// rtl/atm_account_arbiter.sv - round-robin access to one shared account balance
module atm_account_arbiter
    import atm_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 16,
    parameter int INIT_BALANCE = 1000,
    parameter int EXEC_CYCLES  = 2
) (
    input  logic  i_clk,
    input  logic  i_reset,
    atm_arb_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    arb_state_t          r_state, w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic [ID_W-1:0]     r_gidx, w_gidx_nxt;
    logic [1:0]          r_op, w_op_nxt;
    logic [DATA_W-1:0]   r_amount, w_amount_nxt;
    logic [CNT_W-1:0]    r_exec_cnt, w_exec_cnt_nxt;
    logic                r_done, w_done_nxt;
    logic [ID_W-1:0]     r_done_id, w_done_id_nxt;
    logic [1:0]          r_status, w_status_nxt;
    logic [DATA_W-1:0]   r_old_bal, w_old_bal_nxt;
    logic [DATA_W-1:0]   r_new_bal, w_new_bal_nxt;
    logic [DATA_W-1:0]   r_balance, w_balance_nxt;

    logic [NUM_REQ-1:0]  w_arb_onehot;
    logic [ID_W-1:0]     w_arb_idx;
    logic [DATA_W:0]     w_sum;
    logic [1:0]          w_res_status;
    logic [DATA_W-1:0]   w_res_bal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req          (bus.req),
        .i_rr_ptr       (r_rr_ptr),
        .o_grant_onehot (w_arb_onehot),
        .o_grant_idx    (w_arb_idx)
    );

    // Result depends only on latched operands; balance cannot move mid-transaction.
    always_comb begin
        w_sum        = {1'b0, r_balance} + {1'b0, r_amount};
        w_res_status = ST_OK;
        w_res_bal    = r_balance;
        case (r_op)
            OP_INQ: ;
            OP_WDR: begin
                if (r_amount > r_balance) w_res_status = ST_NSF;
                else                      w_res_bal    = r_balance - r_amount;
            end
            OP_DEP: begin
                if (w_sum[DATA_W]) w_res_status = ST_OVF;
                else               w_res_bal    = w_sum[DATA_W-1:0];
            end
            default: w_res_status = ST_ILL;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_nxt    = r_grant;
        w_gidx_nxt     = r_gidx;
        w_op_nxt       = r_op;
        w_amount_nxt   = r_amount;
        w_exec_cnt_nxt = r_exec_cnt;
        w_done_nxt     = 1'b0;
        w_done_id_nxt  = r_done_id;
        w_status_nxt   = r_status;
        w_old_bal_nxt  = r_old_bal;
        w_new_bal_nxt  = r_new_bal;
        w_balance_nxt  = r_balance;
        case (r_state)
            S_IDLE: begin
                // Operands are captured together with grant, so the requester may
                // change them as soon as it sees its grant.
                if (|bus.req) begin
                    w_grant_nxt  = w_arb_onehot;
                    w_gidx_nxt   = w_arb_idx;
                    w_op_nxt     = bus.op[int'(w_arb_idx)*2 +: 2];
                    w_amount_nxt = bus.amount[int'(w_arb_idx)*DATA_W +: DATA_W];
                    w_state_nxt  = S_GRANT;
                end
            end
            S_GRANT: begin
                w_exec_cnt_nxt = CNT_W'(EXEC_CYCLES - 1);
                w_state_nxt    = S_EXEC;
            end
            S_EXEC: begin
                if (r_exec_cnt == '0) begin
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_gidx;
                    w_status_nxt  = w_res_status;
                    w_state_nxt   = S_COMMIT;
                end else begin
                    w_exec_cnt_nxt = r_exec_cnt - 1'b1;
                end
            end
            S_COMMIT: begin
                w_old_bal_nxt = r_balance;
                w_new_bal_nxt = w_res_bal;
                if (r_status == ST_OK) w_balance_nxt = w_res_bal;
                w_rr_ptr_nxt  = (r_gidx == ID_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
                w_grant_nxt   = '0;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_op       <= OP_INQ;
            r_amount   <= '0;
            r_exec_cnt <= '0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_status   <= ST_OK;
            r_old_bal  <= '0;
            r_new_bal  <= '0;
            r_balance  <= DATA_W'(INIT_BALANCE);
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_op       <= w_op_nxt;
            r_amount   <= w_amount_nxt;
            r_exec_cnt <= w_exec_cnt_nxt;
            r_done     <= w_done_nxt;
            r_done_id  <= w_done_id_nxt;
            r_status   <= w_status_nxt;
            r_old_bal  <= w_old_bal_nxt;
            r_new_bal  <= w_new_bal_nxt;
            r_balance  <= w_balance_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.done_id     = r_done_id;
    assign bus.status      = r_status;
    assign bus.old_balance = r_old_bal;
    assign bus.new_balance = r_new_bal;
    assign bus.balance     = r_balance;
endmodule
